code_sequencer: RTL and testbench

//  Parametrised successor of the single-bit bipolar code mapper in the TX chain. Stores up to
//  two binary phase codes (A/B, e.g. Golay complementary pair) and plays them chip by chip on a

---
 rtl/hfswr_tx_pkg.sv | 18 +
 rtl/chip_timer.sv | 45 ++++
 rtl/code_sequencer.sv | 127 ++++++++++++
 tb/tb_code_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hfswr_tx_pkg.sv
// Shared TX-chain definitions: sequencer state encoding
// and full-scale amplitude helpers.
package hfswr_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_st_t;

  function automatic logic signed [63:0] pos_fs(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] neg_fs(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/chip_timer.sv
// Loadable down-counter that times one chip;
// reloads itself at each chip boundary while enabled.
module chip_timer #(
  parameter int CHIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CHIP_CNT_W-1:0] len,
  input  logic                  en,
  output logic                  chip_stb,
  output logic                  chip_last
);

  logic [CHIP_CNT_W-1:0] cnt;
  logic [CHIP_CNT_W-1:0] rld;
  logic [CHIP_CNT_W-1:0] len_m1;

  // a zero length behaves as a one-clock chip
  assign len_m1 = (len == '0) ? '0 : len - CHIP_CNT_W'(1);
  assign chip_last = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rld      <= '0;
      chip_stb <= 1'b0;
    end else begin
      chip_stb <= 1'b0;
      if (load) begin
        cnt      <= len_m1;
        rld      <= len_m1;
        chip_stb <= 1'b1;
      end else if (en) begin
        if (chip_last) begin
          cnt      <= rld;
          chip_stb <= 1'b1;
        end else begin
          cnt <= cnt - CHIP_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/code_sequencer.sv
// Plays binary phase code A/B chip by chip as signed
// full-scale amplitude, with optional per-pulse A/B alternation.
module code_sequencer
  import hfswr_tx_pkg::*;
#(
  parameter  int DATA_W       = 16,
  parameter  int CODE_LEN_MAX = 64,
  parameter  int CHIP_CNT_W   = 16,
  localparam int LEN_W        = $clog2(CODE_LEN_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CODE_LEN_MAX-1:0]  code_a,
  input  logic [CODE_LEN_MAX-1:0]  code_b,
  input  logic [LEN_W-1:0]         code_len,
  input  logic [CHIP_CNT_W-1:0]    chip_len,
  input  logic                     alt_en,
  input  logic                     invert,
  output logic signed [DATA_W-1:0] code_out,
  output logic                     active,
  output logic                     chip_stb,
  output logic                     done,
  output logic                     code_sel,
  output logic                     cfg_err
);

  localparam logic signed [DATA_W-1:0] POS = DATA_W'(pos_fs(DATA_W));
  localparam logic signed [DATA_W-1:0] NEG = DATA_W'(neg_fs(DATA_W));

  seq_st_t                 st;
  logic [CODE_LEN_MAX-1:0] sh;
  logic [CODE_LEN_MAX-1:0] word;
  logic [LEN_W-1:0]        idx;
  logic [LEN_W-1:0]        n_m1;
  logic                    inv;
  logic                    len_ok;
  logic                    go;
  logic                    run;
  logic                    last_idx;
  logic                    fin;
  logic                    chip_last;

  function automatic logic signed [DATA_W-1:0] amp(
    input logic b,
    input logic i
  );
    return (b ^ i) ? POS : NEG;
  endfunction

  assign word     = code_sel ? code_b : code_a;
  assign len_ok   = (code_len != '0) &&
                    (code_len <= LEN_W'(CODE_LEN_MAX));
  assign run      = (st == ST_RUN);
  assign go       = !run && start && len_ok;
  assign last_idx = (idx == n_m1);
  assign fin      = run && !abort && chip_last && last_idx;

  chip_timer #(
    .CHIP_CNT_W (CHIP_CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (go),
    .len       (chip_len),
    .en        (run && !abort && !fin),
    .chip_stb  (chip_stb),
    .chip_last (chip_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= ST_IDLE;
      sh       <= '0;
      idx      <= '0;
      n_m1     <= '0;
      inv      <= 1'b0;
      code_out <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      code_sel <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (start && len_ok) begin
            st       <= ST_RUN;
            sh       <= word >> 1;
            idx      <= '0;
            n_m1     <= code_len - LEN_W'(1);
            inv      <= invert;
            code_out <= amp(word[0], invert);
            active   <= 1'b1;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        ST_RUN: begin
          priority case (1'b1)
            abort: begin
              st       <= ST_IDLE;
              code_out <= '0;
              active   <= 1'b0;
            end
            fin: begin
              st       <= ST_IDLE;
              code_out <= '0;
              active   <= 1'b0;
              done     <= 1'b1;
              code_sel <= alt_en & ~code_sel;
            end
            chip_last: begin
              idx      <= idx + LEN_W'(1);
              sh       <= sh >> 1;
              code_out <= amp(sh[0], inv);
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_sequencer.sv
// Randomised scoreboard bench for code_sequencer against
// a chip-list reference model with cycle-stamped expectations.
module tb_code_sequencer;

  localparam int DW = 16;
  localparam int CM = 64;
  localparam int LW = 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [CM-1:0]        code_a = '0;
  logic [CM-1:0]        code_b = '0;
  logic [LW-1:0]        code_len = '0;
  logic [15:0]          chip_len = '0;
  logic                 alt_en = 1'b0;
  logic                 invert = 1'b0;
  logic signed [DW-1:0] code_out;
  logic                 active;
  logic                 chip_stb;
  logic                 done;
  logic                 code_sel;
  logic                 cfg_err;

  code_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .code_a   (code_a),
    .code_b   (code_b),
    .code_len (code_len),
    .chip_len (chip_len),
    .alt_en   (alt_en),
    .invert   (invert),
    .code_out (code_out),
    .active   (active),
    .chip_stb (chip_stb),
    .done     (done),
    .code_sel (code_sel),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef enum int { K_SMP, K_DONE, K_ERR } kind_t;
  typedef struct {
    kind_t kind;
    int    cyc;
    int    amp;
    bit    stb;
    bit    sel;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  bit   exp_sel = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint want);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
  endtask

  function automatic int amp_of(input bit b, input bit inv);
    return (b ^ inv) ? (1 << (DW - 1)) - 1 : -(1 << (DW - 1));
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // monitor: pop one expectation per reported output cycle
  always @(negedge clk) begin
    exp_t e;
    kind_t k;
    if (!rst) begin
      chk(code_out == 0 && !active && !chip_stb && !done &&
          !cfg_err && !code_sel, "rst_zero", code_out, 0);
    end else if (active || done || cfg_err) begin
      chk(q.size() > 0, "unexpected_out", code_out, 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        k = active ? K_SMP : (done ? K_DONE : K_ERR);
        chk(k == e.kind && (32'(active) + 32'(done) + 32'(cfg_err)) == 1,
            "out_kind", k, e.kind);
        chk(e.cyc == cyc, "out_time", cyc, e.cyc);
        chk(code_sel == e.sel, "code_sel", code_sel, e.sel);
        if (e.kind == K_SMP) begin
          chk(code_out == e.amp, "chip_amp", code_out, e.amp);
          chk(chip_stb == e.stb, "chip_stb", chip_stb, e.stb);
        end else begin
          chk(code_out == 0 && !chip_stb, "quiet_out", code_out, 0);
        end
      end
    end else begin
      chk(code_out == 0 && !chip_stb, "idle_zero", code_out, 0);
      if (q.size() > 0)
        chk(q[0].cyc >= cyc, "missed_out", cyc, q[0].cyc);
    end
  end

  task automatic push_seq(input int t, input logic [63:0] a,
                          input logic [63:0] b, input int n, input int l,
                          input bit inv, input bit alt, input int lim,
                          input bit dn);
    int el;
    logic [63:0] w;
    exp_t e;
    el = (l == 0) ? 1 : l;
    w  = exp_sel ? b : a;
    for (int k = 0; k < n * el && k < lim; k++) begin
      e.kind = K_SMP;
      e.cyc  = t + k;
      e.amp  = amp_of(w[k / el], inv);
      e.stb  = (k % el) == 0;
      e.sel  = exp_sel;
      q.push_back(e);
    end
    if (dn) begin
      exp_sel = alt ? !exp_sel : 1'b0;
      e.kind = K_DONE;
      e.cyc  = t + n * el;
      e.amp  = 0;
      e.stb  = 1'b0;
      e.sel  = exp_sel;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_seq(input logic [63:0] a, input logic [63:0] b,
                           input int n, input int l, input bit inv,
                           input bit alt, input int ab_k, input bit ab_st,
                           input bit noise);
    int t, tot, nw;
    code_a = a;
    code_b = b;
    code_len = LW'(n);
    chip_len = 16'(l);
    invert = inv;
    alt_en = alt;
    start = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    start = 1'b0;
    tot = n * ((l == 0) ? 1 : l);
    nw = (ab_k > 0) ? ab_k : tot;
    push_seq(t, a, b, n, l, inv, alt, nw, ab_k == 0);
    for (int j = 1; j <= nw; j++) begin
      if (noise) begin
        code_a = r64();
        code_b = r64();
        code_len = LW'($urandom);
        chip_len = 16'($urandom);
        invert = 1'($urandom);
        start = 1'($urandom);
      end
      if (ab_k > 0 && j == nw) begin
        abort = 1'b1;
        start = ab_st;
      end
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic bad_start(input int len);
    exp_t e;
    code_len = LW'(len);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.kind = K_ERR;
    e.cyc  = cyc;
    e.amp  = 0;
    e.stb  = 1'b0;
    e.sel  = exp_sel;
    q.push_back(e);
  endtask

  initial begin
    int n, l, tot, ab, t;
    logic [63:0] ra;
    idle(3);
    rst = 1'b1;
    idle(100);

    start_seq(64'h1F35, 64'h0, 13, 4, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(2);

    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 3; s++) begin
        start_seq(64'b0111, 64'b1011, 4, 1, 1'(p), 1'b1, 0, 1'b0, 1'b0);
        idle(1);
      end
    end

    start_seq(r64(), r64(), CM, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    start_seq(64'h1, 64'h0, 1, 65535, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    start_seq(r64(), r64(), 5, 2, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    start_seq(r64(), r64(), 3, 1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    idle(2);

    start_seq(r64(), r64(), 10, 3, 1'b0, 1'b1, 7 * 3 + 1, 1'b0, 1'b1);
    idle(2);
    start_seq(r64(), r64(), 6, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
    idle(1);
    start_seq(r64(), r64(), 4, 2, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(2);

    bad_start(0);
    bad_start(65);
    idle(1);
    bad_start(127);
    idle(2);

    ra = r64();
    code_a = ra;
    code_b = r64();
    code_len = 8;
    chip_len = 5;
    invert = 1'b0;
    alt_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    start = 1'b0;
    push_seq(t, ra, code_b, 8, 5, 1'b0, 1'b0, 40, 1'b1);
    idle(12);
    #6;
    rst = 1'b0;
    #1;
    chk(code_out == 0 && !active && !chip_stb, "async_rst", code_out, 0);
    q.delete();
    exp_sel = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(3);
    start_seq(ra, r64(), 8, 5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(2);

    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 20);
      l = $urandom_range(0, 3);
      tot = n * ((l == 0) ? 1 : l);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot) : 0;
      start_seq(r64(), r64(), n, l, 1'($urandom), 1'($urandom), ab,
                1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(5);
    chk(q.size() == 0, "queue_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
